// File: rtl/adder_sum_serializer.sv
// adder_sum_serializer: buffers wide sum words from the non-stallable adder
// pipeline in a small FIFO and emits each word as narrow beats, LSB first,
// on a valid/ready stream. Exposes fill for upstream throttling and a sticky
// overflow flag for any word that arrives with nowhere to go.
module adder_sum_serializer #(
   parameter int IN_WIDTH  = 1024,
   parameter int OUT_WIDTH = 128,
   parameter int DEPTH     = 2
) (
   input  logic                         clk,
   input  logic                         resetn,   // active-high despite the name
   input  logic                         in_valid,
   input  logic [IN_WIDTH-1:0]          in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_data,
   output logic                         out_last,
   output logic [$clog2(DEPTH+1)-1:0]   fill,
   output logic                         overflow
);

   localparam int N  = IN_WIDTH / OUT_WIDTH;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FW = $clog2(DEPTH + 1);

   // A word viewed as an array of beats; beat 0 is the least-significant slice.
   typedef logic [N-1:0][OUT_WIDTH-1:0] word_t;

   word_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] idx;

   logic xfer, last_beat, pop, push, drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake and FIFO decisions; a push is still allowed when full if the
   // head word leaves at the same edge, since the adder cannot be stalled.
   always_comb begin
      in_ready  = (fill < FW'(DEPTH));
      out_valid = (fill != '0);
      last_beat = (idx == IW'(N - 1));
      out_last  = out_valid && last_beat;
      out_data  = out_valid ? mem[rd_ptr][idx] : '0;
      xfer      = out_valid && out_ready;
      pop       = xfer && last_beat;
      push      = in_valid && (in_ready || pop);
      drop      = in_valid && !push;
   end

   // Word storage; data needs no reset because out_data is masked by out_valid.
   // When full with push-on-pop, wr_ptr equals rd_ptr, but the head word is
   // retired at that same edge so nothing still being sent is overwritten.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word_t'(in_data);
   end

   // Pointers, fill count, beat index and sticky overflow.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         idx      <= '0;
         fill     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (xfer) idx    <= last_beat ? '0 : idx + IW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adder_sum_serializer.sv
// Scoreboard bench for adder_sum_serializer (default 1024/128/2 config).
// Stimulus pushes expected beats into a queue; a negedge monitor pops and
// compares each transferred beat and checks stability during stalls.
module tb_adder_sum_serializer;

   localparam int IW = 1024;
   localparam int OW = 128;
   localparam int N  = IW / OW;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic [1:0]    fill;
   logic          overflow;

   adder_sum_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(2)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .fill(fill), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] d;
      logic          l;
   } beat_t;

   beat_t q[$];
   int    checks   = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Word whose beat k holds base+k.
   function automatic logic [IW-1:0] mk(input int base);
      logic [IW-1:0] w;
      for (int k = 0; k < N; k++) w[k*OW +: OW] = OW'(base + k);
      return w;
   endfunction

   function automatic void expect_word(input logic [IW-1:0] w);
      for (int k = 0; k < N; k++) q.push_back('{w[k*OW +: OW], (k == N - 1)});
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q.delete();
      resetn = 1'b0;
      cyc();
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         cyc();
         n++;
      end
      chk(name, OW'(q.size()), '0);
   endtask

   // Monitor: compare every transferred beat and hold-stability on stalls.
   logic          prev_stall = 1'b0;
   logic [OW-1:0] prev_d;
   logic          prev_l;
   always @(negedge clk) begin
      if (resetn) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && out_valid) begin
            chk("stall_data_hold", out_data, prev_d);
            chk("stall_last_hold", OW'(out_last), OW'(prev_l));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", out_data, 'x);
            end else begin
               beat_t e;
               e = q.pop_front();
               chk("beat_data", out_data, e.d);
               chk("beat_last", OW'(out_last), OW'(e.l));
            end
         end
         prev_stall <= out_valid && !out_ready;
         prev_d     <= out_data;
         prev_l     <= out_last;
      end
   end

   initial begin
      logic [IW-1:0] w0, w1, w2;
      int bubbles;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      resetn = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      #3;
      // Reset state
      chk("rst_out_valid", OW'(out_valid), '0);
      chk("rst_out_last", OW'(out_last), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_fill", OW'(fill), '0);
      chk("rst_overflow", OW'(overflow), '0);
      chk("rst_in_ready", OW'(in_ready), OW'(1));
      do_reset();

      // Single word, out_ready=1
      out_ready = 1'b1;
      w0 = mk(0);
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      chk("single_pre_valid", OW'(out_valid), '0);
      cyc();
      in_valid = 1'b0;
      chk("single_valid_latency", OW'(out_valid), OW'(1));
      chk("single_first_beat", out_data, '0);
      drain("single_drain");
      chk("single_end_valid", OW'(out_valid), '0);
      chk("single_end_fill", OW'(fill), '0);

      // Backpressure: out_ready pattern 1,0,0,1
      w0 = mk('h40);
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 60 && q.size() != 0; i++) begin
         out_ready = pat[i % 4];
         cyc();
      end
      chk("bp_drain", OW'(q.size()), '0);
      out_ready = 1'b0;
      cyc();
      chk("bp_end_fill", OW'(fill), '0);

      // Fill and drop
      w0 = mk('h100); w1 = mk('h200); w2 = mk('h300);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      cyc();
      chk("fd_fill1", OW'(fill), OW'(1));
      in_data = w1; expect_word(w1);
      cyc();
      chk("fd_fill2", OW'(fill), OW'(2));
      chk("fd_in_ready", OW'(in_ready), '0);
      in_data = w2;
      cyc();
      in_valid = 1'b0;
      chk("fd_overflow", OW'(overflow), OW'(1));
      chk("fd_fill_after_drop", OW'(fill), OW'(2));
      out_ready = 1'b1;
      drain("fd_drain");
      chk("fd_overflow_sticky", OW'(overflow), OW'(1));

      // Push-on-pop with a full FIFO
      do_reset();
      w0 = mk('h400); w1 = mk('h500); w2 = mk('h600);
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      cyc();
      in_data = w1; expect_word(w1);
      cyc();
      in_valid = 1'b0;
      chk("pop_full", OW'(fill), OW'(2));
      out_ready = 1'b1;
      repeat (7) cyc();
      chk("pop_at_last", OW'(out_last), OW'(1));
      in_valid = 1'b1; in_data = w2; expect_word(w2);
      cyc();
      in_valid = 1'b0;
      chk("pop_fill_kept", OW'(fill), OW'(2));
      chk("pop_no_overflow", OW'(overflow), '0);
      drain("pop_drain");

      // Asynchronous reset mid-word
      w0 = mk('h700);
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      cyc();
      in_valid = 1'b0;
      repeat (4) cyc();
      chk("mid_beat4", out_data, OW'('h704));
      #2 resetn = 1'b1;
      #1;
      chk("mid_rst_valid", OW'(out_valid), '0);
      chk("mid_rst_fill", OW'(fill), '0);
      chk("mid_rst_overflow", OW'(overflow), '0);
      q.delete();
      resetn = 1'b0;
      cyc();
      w0 = mk('h800);
      in_valid = 1'b1; in_data = w0; expect_word(w0);
      cyc();
      in_valid = 1'b0;
      chk("mid_restart_beat0", out_data, OW'('h800));
      drain("mid_drain");

      // Back-to-back streaming, 4 words every 8 cycles
      bubbles = 0;
      for (int i = 0; i < 4 * N; i++) begin
         if (i % N == 0) begin
            w0 = mk('h1000 * (i / N + 1));
            in_valid = 1'b1; in_data = w0; expect_word(w0);
         end
         cyc();
         in_valid = 1'b0;
         if (!out_valid) bubbles++;
      end
      chk("stream_bubbles", OW'(bubbles), '0);
      drain("stream_drain");
      chk("stream_overflow", OW'(overflow), '0);
      chk("stream_end_valid", OW'(out_valid), '0);

      repeat (2) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
